// File: rtl/game_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : game_frame_ctrl
// Purpose  : Once-per-frame game sequencer for the VGA maze game. Latches the
//            keyboard direction flags on frame_tick, computes the next sprite
//            position (gravity + border clamp), checks it against four fixed
//            walls one per cycle, then commits it.
// Revision : 1.0  initial release
// ============================================================================
module game_frame_ctrl #(
    parameter int START_X = 10,
    parameter int START_Y = 10,
    parameter int STEP    = 1,
    parameter int SPRITE  = 10,
    parameter int X_MAX   = 620,
    parameter int Y_MIN   = 10,
    parameter int Y_MAX   = 460,
    parameter int X_MIN   = 10
) (
    input  logic        sysclk,
    input  logic        rst_n,
    input  logic        frame_tick,
    input  logic        key_left,
    input  logic        key_right,
    input  logic        key_up,
    input  logic        key_start,
    output logic [9:0]  pos_x,
    output logic [9:0]  pos_y,
    output logic [1:0]  state,
    output logic        busy,
    output logic [15:0] frames,
    output logic        tick_miss
);

    localparam logic [9:0]         START_X_V = 10'(START_X);
    localparam logic [9:0]         START_Y_V = 10'(START_Y);
    localparam logic [9:0]         X_MAX_V   = 10'(X_MAX);
    localparam logic signed [10:0] STEP_S    = 11'(STEP);
    localparam logic signed [10:0] X_MIN_S   = 11'(X_MIN);
    localparam logic signed [10:0] X_MAX_S   = 11'(X_MAX);
    localparam logic signed [10:0] Y_MIN_S   = 11'(Y_MIN);
    localparam logic signed [10:0] Y_MAX_S   = 11'(Y_MAX);
    localparam logic [10:0]        SPR       = 11'(SPRITE);
    localparam logic [10:0]        WALL_W    = 11'd10;

    typedef enum logic [3:0] {
        S_IDLE, S_WAIT, S_MOVE, S_CHK0, S_CHK1, S_CHK2, S_CHK3,
        S_COMMIT, S_DEAD, S_WIN
    } fsm_t;

    fsm_t               st, st_nxt;
    logic               restart;
    logic               lat_l, lat_r, lat_u;
    logic [9:0]         cand_x, cand_y;
    logic               hit;
    logic signed [10:0] dx, dy, mv_x, mv_y, clamp_x, clamp_y;
    logic [10:0]        wall_x, gap_top, gap_bot, ext_x, ext_y;
    logic               wall_hit;

    // Externally visible 2-bit game state for a given internal state
    function automatic logic [1:0] state_code(input fsm_t s);
        case (s)
            S_IDLE:  state_code = 2'b00;
            S_DEAD:  state_code = 2'b10;
            S_WIN:   state_code = 2'b11;
            default: state_code = 2'b01;
        endcase
    endfunction

    // Frame update in flight: from the move calculation through commit
    function automatic logic busy_code(input fsm_t s);
        case (s)
            S_MOVE, S_CHK0, S_CHK1, S_CHK2, S_CHK3, S_COMMIT: busy_code = 1'b1;
            default:                                          busy_code = 1'b0;
        endcase
    endfunction

    // State register; state/busy are registered from the next state so they
    // change on the same edge as the FSM
    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            st    <= S_IDLE;
            state <= 2'b00;
            busy  <= 1'b0;
        end else begin
            st    <= st_nxt;
            state <= state_code(st_nxt);
            busy  <= busy_code(st_nxt);
        end
    end

    // Next-state logic; restart wins over a coincident frame_tick
    always_comb begin
        st_nxt  = st;
        restart = 1'b0;
        case (st)
            S_IDLE, S_DEAD, S_WIN: begin
                if (key_start) begin
                    st_nxt  = S_WAIT;
                    restart = 1'b1;
                end
            end
            S_WAIT:   if (frame_tick) st_nxt = S_MOVE;
            S_MOVE:   st_nxt = S_CHK0;
            S_CHK0:   st_nxt = S_CHK1;
            S_CHK1:   st_nxt = S_CHK2;
            S_CHK2:   st_nxt = S_CHK3;
            S_CHK3:   st_nxt = S_COMMIT;
            S_COMMIT: begin
                if (hit)                    st_nxt = S_DEAD;
                else if (cand_x == X_MAX_V) st_nxt = S_WIN;
                else                        st_nxt = S_WAIT;
            end
            default:  st_nxt = S_IDLE;
        endcase
    end

    // Candidate position: signed step, gravity, clamp without wrap-around
    always_comb begin
        dx = '0;
        if (lat_r && !lat_l)      dx = STEP_S;
        else if (lat_l && !lat_r) dx = -STEP_S;
        dy   = lat_u ? -STEP_S : STEP_S;
        mv_x = $signed({1'b0, pos_x}) + dx;
        mv_y = $signed({1'b0, pos_y}) + dy;
        if (mv_x < X_MIN_S)      clamp_x = X_MIN_S;
        else if (mv_x > X_MAX_S) clamp_x = X_MAX_S;
        else                     clamp_x = mv_x;
        if (mv_y < Y_MIN_S)      clamp_y = Y_MIN_S;
        else if (mv_y > Y_MAX_S) clamp_y = Y_MAX_S;
        else                     clamp_y = mv_y;
    end

    // Wall table lookup and collision test for the wall of the current check
    always_comb begin
        wall_x  = 11'd180;
        gap_top = 11'd300;
        gap_bot = 11'd400;
        case (st)
            S_CHK1: begin wall_x = 11'd280; gap_top = 11'd200; gap_bot = 11'd250; end
            S_CHK2: begin wall_x = 11'd380; gap_top = 11'd150; gap_bot = 11'd200; end
            S_CHK3: begin wall_x = 11'd480; gap_top = 11'd370; gap_bot = 11'd420; end
            default: ;
        endcase
        ext_x    = {1'b0, cand_x};
        ext_y    = {1'b0, cand_y};
        wall_hit = (ext_x + SPR > wall_x) && (ext_x < wall_x + WALL_W) &&
                   ((ext_y < gap_top) || (ext_y + SPR > gap_bot));
    end

    // Datapath: key latch, candidate, hit accumulation, commit, counters
    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            pos_x     <= START_X_V;
            pos_y     <= START_Y_V;
            frames    <= '0;
            tick_miss <= 1'b0;
            lat_l     <= 1'b0;
            lat_r     <= 1'b0;
            lat_u     <= 1'b0;
            cand_x    <= START_X_V;
            cand_y    <= START_Y_V;
            hit       <= 1'b0;
        end else begin
            if (frame_tick && busy) tick_miss <= 1'b1;
            case (st)
                S_WAIT: begin
                    if (frame_tick) begin
                        lat_l <= key_left;
                        lat_r <= key_right;
                        lat_u <= key_up;
                    end
                end
                S_MOVE: begin
                    cand_x <= clamp_x[9:0];
                    cand_y <= clamp_y[9:0];
                    hit    <= 1'b0;
                end
                S_CHK0, S_CHK1, S_CHK2, S_CHK3: begin
                    if (wall_hit) hit <= 1'b1;
                end
                S_COMMIT: begin
                    pos_x <= cand_x;
                    pos_y <= cand_y;
                    if (!hit && (cand_x != X_MAX_V) && (frames != 16'hFFFF))
                        frames <= frames + 16'd1;
                end
                default: ;
            endcase
            if (restart) begin
                pos_x  <= START_X_V;
                pos_y  <= START_Y_V;
                frames <= '0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_game_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_game_frame_ctrl
// Purpose  : Self-checking bench for game_frame_ctrl. A frame-level model
//            predicts every output each cycle; directed scenarios add literal
//            expectations for movement, clamping, death, win, restart,
//            dropped ticks and asynchronous reset.
// Revision : 1.0  initial release
// ============================================================================
module tb_game_frame_ctrl;

    logic sysclk = 1'b0;
    always #5 sysclk = ~sysclk;

    logic        rst_n = 1'b0, frame_tick = 1'b0;
    logic        key_left = 1'b0, key_right = 1'b0, key_up = 1'b0, key_start = 1'b0;
    logic [9:0]  pos_x, pos_y;
    logic [1:0]  state;
    logic        busy, tick_miss;
    logic [15:0] frames;

    game_frame_ctrl dut (
        .sysclk(sysclk), .rst_n(rst_n), .frame_tick(frame_tick),
        .key_left(key_left), .key_right(key_right), .key_up(key_up),
        .key_start(key_start), .pos_x(pos_x), .pos_y(pos_y), .state(state),
        .busy(busy), .frames(frames), .tick_miss(tick_miss)
    );

    // Second instance spawning next to the right border for the win case
    logic        w_rst_n = 1'b0, w_tick = 1'b0, w_right = 1'b0, w_start = 1'b0;
    logic [9:0]  w_pos_x, w_pos_y;
    logic [1:0]  w_state;
    logic        w_busy, w_miss;
    logic [15:0] w_frames;

    game_frame_ctrl #(.START_X(615)) u_win (
        .sysclk(sysclk), .rst_n(w_rst_n), .frame_tick(w_tick),
        .key_left(1'b0), .key_right(w_right), .key_up(1'b0),
        .key_start(w_start), .pos_x(w_pos_x), .pos_y(w_pos_y), .state(w_state),
        .busy(w_busy), .frames(w_frames), .tick_miss(w_miss)
    );

    int n_pass = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // ---------------- frame-level model of the main instance ----------------
    localparam int WX [4] = '{180, 280, 380, 480};
    localparam int GT [4] = '{300, 200, 150, 370};
    localparam int GB [4] = '{400, 250, 200, 420};

    int m_x = 10, m_y = 10, m_frames = 0, m_mode = 0, m_cd = 0;
    int n_x, n_y, dxm;
    bit m_miss = 1'b0, n_hit;

    function automatic bit model_hit(input int x, input int y);
        for (int i = 0; i < 4; i++)
            if (x + 10 > WX[i] && x < WX[i] + 10 && (y < GT[i] || y + 10 > GB[i]))
                return 1'b1;
        return 1'b0;
    endfunction

    function automatic int clampi(input int v, input int lo, input int hi);
        return (v < lo) ? lo : ((v > hi) ? hi : v);
    endfunction

    // m_cd counts edges until the pending frame result becomes visible
    initial begin : model
        forever begin
            @(posedge sysclk or negedge rst_n);
            if (!rst_n) begin
                m_x = 10; m_y = 10; m_frames = 0; m_mode = 0; m_cd = 0; m_miss = 1'b0;
            end else if (m_cd > 0) begin
                if (frame_tick) m_miss = 1'b1;
                m_cd--;
                if (m_cd == 0) begin
                    m_x = n_x; m_y = n_y;
                    if (n_hit)            m_mode = 2;
                    else if (n_x == 620)  m_mode = 3;
                    else if (m_frames < 65535) m_frames++;
                end
            end else if (m_mode != 1) begin
                if (key_start) begin
                    m_x = 10; m_y = 10; m_frames = 0; m_mode = 1;
                end
            end else if (frame_tick) begin
                dxm   = (key_right && !key_left) ? 1 : ((key_left && !key_right) ? -1 : 0);
                n_x   = clampi(m_x + dxm, 10, 620);
                n_y   = clampi(m_y + (key_up ? -1 : 1), 10, 460);
                n_hit = model_hit(n_x, n_y);
                m_cd  = 6;
            end
        end
    end

    // Per-cycle comparison of every main-instance output against the model
    initial begin : compare
        logic [39:0] exp_v;
        forever begin
            @(negedge sysclk);
            exp_v = {2'(m_mode), (m_cd > 0), m_miss, 16'(m_frames), 10'(m_x), 10'(m_y)};
            check("cycle", {state, busy, tick_miss, frames, pos_x, pos_y}, exp_v);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic do_reset();
        rst_n = 1'b0; frame_tick = 1'b0; key_start = 1'b0;
        key_left = 1'b0; key_right = 1'b0; key_up = 1'b0;
        repeat (2) @(negedge sysclk);
        rst_n = 1'b1;
        @(negedge sysclk);
    endtask

    task automatic start_run();
        key_start = 1'b1;
        @(negedge sysclk);
        key_start = 1'b0;
        @(negedge sysclk);
    endtask

    task automatic tick_wait();
        frame_tick = 1'b1;
        @(negedge sysclk);
        frame_tick = 1'b0;
        repeat (7) @(negedge sysclk);
    endtask

    task automatic w_tick_wait();
        w_tick = 1'b1;
        @(negedge sysclk);
        w_tick = 1'b0;
        repeat (7) @(negedge sysclk);
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded its time budget");
        $fatal(1, "timeout");
    end

    initial begin : stim
        // Reset values
        do_reset();
        check("reset_pos", {pos_x, pos_y}, {10'd10, 10'd10});
        check("reset_state", {state, busy, tick_miss, frames}, {2'b00, 1'b0, 1'b0, 16'd0});

        // Start and tick together in IDLE: restart only, no move
        key_start = 1'b1; frame_tick = 1'b1;
        @(negedge sysclk);
        key_start = 1'b0; frame_tick = 1'b0;
        repeat (8) @(negedge sysclk);
        check("start_tick_pos", {pos_x, pos_y}, {10'd10, 10'd10});
        check("start_tick_state", {state, frames}, {2'b01, 16'd0});

        // First right move: exact latency, keys changed after the latch edge
        key_right = 1'b1;
        frame_tick = 1'b1;
        @(negedge sysclk);
        frame_tick = 1'b0; key_right = 1'b0; key_left = 1'b1;
        repeat (5) @(negedge sysclk);
        check("latency_before", {pos_x, busy}, {10'd10, 1'b1});
        @(negedge sysclk);
        check("latency_after", {pos_x, pos_y, busy}, {10'd11, 10'd11, 1'b0});
        key_left = 1'b0; key_right = 1'b1;
        @(negedge sysclk);
        repeat (4) tick_wait();
        check("right5_pos", {pos_x, pos_y}, {10'd15, 10'd15});
        check("right5_state", {state, frames}, {2'b01, 16'd5});

        // Left+up from spawn: clamped at both minima, no wrap
        do_reset();
        start_run();
        key_left = 1'b1; key_up = 1'b1;
        repeat (3) tick_wait();
        check("clamp_pos", {pos_x, pos_y}, {10'd10, 10'd10});
        check("clamp_frames", frames, 16'd3);

        // Right+up into the first wall
        do_reset();
        start_run();
        key_right = 1'b1; key_up = 1'b1;
        repeat (160) tick_wait();
        check("pre_wall", {state, frames, pos_x, pos_y}, {2'b01, 16'd160, 10'd170, 10'd10});
        tick_wait();
        check("dead_pos", {pos_x, pos_y}, {10'd171, 10'd10});
        check("dead_state", {state, frames}, {2'b10, 16'd160});
        tick_wait();
        check("dead_frozen", {pos_x, pos_y, state, busy, tick_miss},
              {10'd171, 10'd10, 2'b10, 1'b0, 1'b0});

        // Restart from DEAD, then a tick dropped while busy
        start_run();
        check("restart_dead", {state, frames, pos_x, pos_y}, {2'b01, 16'd0, 10'd10, 10'd10});
        frame_tick = 1'b1; @(negedge sysclk);
        frame_tick = 1'b0; @(negedge sysclk);
        frame_tick = 1'b1; @(negedge sysclk);
        frame_tick = 1'b0;
        repeat (8) @(negedge sysclk);
        check("miss_one_update", {pos_x, pos_y, frames}, {10'd11, 10'd10, 16'd1});
        check("miss_flag", tick_miss, 1'b1);

        // Asynchronous reset three edges into an update
        frame_tick = 1'b1; @(negedge sysclk);
        frame_tick = 1'b0;
        repeat (2) @(negedge sysclk);
        @(posedge sysclk);
        #2;
        check("busy_mid", busy, 1'b1);
        rst_n = 1'b0;
        #1;
        check("async_rst_pos", {pos_x, pos_y}, {10'd10, 10'd10});
        check("async_rst_ctl", {state, busy, tick_miss, frames}, {2'b00, 1'b0, 1'b0, 16'd0});
        @(negedge sysclk);
        rst_n = 1'b1;
        key_right = 1'b0; key_up = 1'b0;
        @(negedge sysclk);

        // Win instance: spawn at 615, one dropped tick, reach the win column
        w_rst_n = 1'b1;
        @(negedge sysclk);
        w_start = 1'b1; @(negedge sysclk);
        w_start = 1'b0; @(negedge sysclk);
        w_right = 1'b1;
        w_tick = 1'b1; @(negedge sysclk);
        w_tick = 1'b0; @(negedge sysclk);
        w_tick = 1'b1; @(negedge sysclk);
        w_tick = 1'b0;
        repeat (8) @(negedge sysclk);
        check("win_first", {w_pos_x, w_pos_y, w_miss}, {10'd616, 10'd11, 1'b1});
        repeat (4) w_tick_wait();
        check("win_pos", {w_pos_x, w_pos_y}, {10'd620, 10'd15});
        check("win_state", {w_state, w_frames}, {2'b11, 16'd4});
        w_tick_wait();
        check("win_frozen", {w_pos_x, w_state, w_busy}, {10'd620, 2'b11, 1'b0});
        w_start = 1'b1; @(negedge sysclk);
        w_start = 1'b0; @(negedge sysclk);
        check("win_restart", {w_pos_x, w_pos_y, w_frames, w_state},
              {10'd615, 10'd10, 16'd0, 2'b01});
        check("miss_sticky", w_miss, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
